rs_encode_line_out_datap: RTL and testbench
===========================================

Name: rs_encode_line_out_datap

Overview:
- Output-side packer for the Reed-Solomon encoder.
- Accepts one RS_WORD_W symbol per handshake from the encoder output (data plus parity stream). Packs symbols MSB-first into DATA_W lines and presents each completed line to the downstream line sink with a valid/ready handshake.
- It is the mirror of the line-to-symbol input serializer: a block of NUM_LINES lines, where the final line carries LAST_LINE_BYTES symbols and is zero-padded.

Parameters:
- DATA_W, 512, output line width in bits; must be a multiple of 8.
- DATA_BYTES, DATA_W/8, symbols per line.
- DATA_BYTES_W, $clog2(DATA_BYTES), byte offset width.
- NUM_LINES, 4, lines per encoded block; must be >= 1.
- NUM_LINES_W, $clog2(NUM_LINES) (min 1), line counter width.
- LAST_LINE_BYTES, DATA_BYTES, valid symbols in the final line; range 1..DATA_BYTES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- encoder_out_data_val  in  1  encoder symbol valid
- encoder_out_data  in  RS_WORD_W  encoder symbol
- out_encoder_data_rdy  out  1  packer can accept symbol
- out_dst_line_val  out  1  packed line valid
- out_dst_line  out  DATA_W  packed line; first symbol in bits [DATA_W-1 -: 8]
- out_dst_line_last  out  1  line is final line of block; qualified by val
- dst_out_line_rdy  in  1  downstream accepts line

Behaviour:
- Reset: rst synchronous, active-high, clock clk. Reset is honoured in any state, including mid-line or mid-SEND; partial data is discarded.
  - state=FILL, byte_offset=0, line_count=0, line_reg=0.
  - out_dst_line_val=0, out_dst_line=0, out_dst_line_last=0.
  - out_encoder_data_rdy=1 in the first cycle after reset.
- State machine (2 states):
  - FILL:
    - out_encoder_data_rdy=1, out_dst_line_val=0.
    - On symbol handshake (val&rdy): write byte lane (DATA_BYTES-1-byte_offset) of line_reg.
    - If that symbol is the last of the line: byte_offset<=0 and go to SEND next cycle. Otherwise byte_offset+=1.
  - SEND:
    - out_encoder_data_rdy=0, out_dst_line_val=1, out_dst_line=line_reg.
    - out_dst_line_last = (line_count==NUM_LINES-1).
    - val is held and the line is stable until dst_out_line_rdy.
    - On line handshake: line_reg<=0 and go to FILL.
    - line_count: wraps to 0 if the line was last, else increments.
- Last-symbol-of-line condition:
  - Not on the final line: byte_offset==DATA_BYTES-1.
  - On the final line (line_count==NUM_LINES-1): byte_offset==LAST_LINE_BYTES-1.
- Zero padding: line_reg is cleared on every line handshake. The unwritten lanes of a short final line are therefore 0.
- Latency:
  - Last symbol accepted in cycle N -> out_dst_line_val high in cycle N+1.
  - Line accepted in cycle M -> out_encoder_data_rdy high in cycle M+1.
- Throughput: one symbol per cycle during FILL. At least one bubble cycle per line (single-buffered by design).
- Arithmetic: byte_offset and line_count are unsigned. They never exceed their terminal values and wrap by explicit clear, not by overflow.
- Block boundary: after the final line is accepted, counters return to 0. The next symbol starts a new block with no idle gap.
- Symbols are never dropped or duplicated. Encoder val held during SEND is not consumed.
- NUM_LINES=1: every line is last. LAST_LINE_BYTES=DATA_BYTES: no padding.

Decomposition:
- RS_WORD_W (8) comes from rs_encode_pkg.
- Add to rs_encode_pkg: typedef enum logic {FILL, SEND} rs_line_out_state_e.
- Split into two parts:
  - rs_encode_line_out_ctrl: FSM plus handshakes.
  - Datapath (counters, line_reg, lane write) stays in rs_encode_line_out_datap.
  - Ctrl/datap interface: init_state, store_byte, clear_line, incr_line; datap returns last_line_byte and last_line.

Test Plan:
- Config DATA_W=32, NUM_LINES=3, LAST_LINE_BYTES=2.
- Stream 0x01..0x0A back-to-back, sink always ready -> lines 0x01020304 (last=0), 0x05060708 (last=0), 0x090A0000 (last=1). rdy is low exactly one cycle after each line fills.
- Same stream, dst_out_line_rdy low for 5 cycles on line 2 -> line held at 0x05060708 with val=1 for 6 cycles. out_encoder_data_rdy=0 throughout; byte 0x09 is not consumed until the cycle after the handshake.
- Random encoder val gaps (50%), two consecutive blocks 0x01..0x14 -> six lines; the second block's lines are 0x0B0C0D0E, 0x0F101112, 0x13140000 with last on lines 3 and 6.
- Assert rst after 2 symbols of line 2 -> outputs return to 0 next cycle. Restarting with 0xA1..0xAA yields first line 0xA1A2A3A4 with last=0.
- Config NUM_LINES=1, LAST_LINE_BYTES=4 (DATA_W=32): symbols 0xDE,0xAD,0xBE,0xEF -> line 0xDEADBEEF with last=1. Counters return to 0 after handshake.

Source files
------------

// File: rtl/rs_encode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_encode_pkg
// Description : Shared types and constants for the Reed-Solomon encoder
//               datapath blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package rs_encode_pkg;

  // Width of one Reed-Solomon symbol.
  localparam int RS_WORD_W = 8;

  // Line packer states: gathering symbols, or offering a completed line.
  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } rs_line_out_state_e;

  // Counter width helper: a counter always has at least one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_encode_line_out_datap_if.sv
`default_nettype none
// ============================================================================
// Module      : rs_encode_line_out_datap_if
// Description : Symbol-in / line-out handshake bundle of the RS line packer.
//               slave = packer view, master = encoder/sink view.
// Revision    : 1.0 - initial release
// ============================================================================
interface rs_encode_line_out_datap_if #(
  parameter int DATA_W = 512
);
  import rs_encode_pkg::*;

  logic                 encoder_out_data_val;
  logic [RS_WORD_W-1:0] encoder_out_data;
  logic                 out_encoder_data_rdy;
  logic                 out_dst_line_val;
  logic [DATA_W-1:0]    out_dst_line;
  logic                 out_dst_line_last;
  logic                 dst_out_line_rdy;

  modport slave (
    input  encoder_out_data_val,
    input  encoder_out_data,
    input  dst_out_line_rdy,
    output out_encoder_data_rdy,
    output out_dst_line_val,
    output out_dst_line,
    output out_dst_line_last
  );

  modport master (
    output encoder_out_data_val,
    output encoder_out_data,
    output dst_out_line_rdy,
    input  out_encoder_data_rdy,
    input  out_dst_line_val,
    input  out_dst_line,
    input  out_dst_line_last
  );

endinterface
`default_nettype wire

// File: rtl/rs_encode_line_out_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rs_encode_line_out_ctrl
// Description : Two-state controller of the RS line packer. Owns both
//               handshakes and tells the datapath when to store a symbol,
//               clear the line and advance the line counter.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_encode_line_out_ctrl
  import rs_encode_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sym_val,         // encoder symbol valid
  input  logic line_rdy,        // downstream accepts line
  input  logic last_line_byte,  // current symbol completes the line
  output logic sym_rdy,
  output logic line_val,
  output logic init_state,      // return datapath to its block-start state
  output logic store_byte,      // write current symbol into the line
  output logic clear_line,      // line handed off, clear the buffer
  output logic incr_line        // line handed off, advance line counter
);

  rs_line_out_state_e r_state;
  logic               r_sym_rdy;
  logic               r_line_val;

  // Reset of the datapath is driven from here so one block owns reset policy.
  assign init_state = rst;
  assign store_byte = sym_val & r_sym_rdy;
  assign clear_line = r_line_val & line_rdy;
  assign incr_line  = clear_line;
  assign sym_rdy    = r_sym_rdy;
  assign line_val   = r_line_val;

  // FSM with registered handshake outputs: symbol ready in FILL, line valid in SEND.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FILL;
      r_sym_rdy  <= 1'b1;
      r_line_val <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (store_byte && last_line_byte) begin
            r_state    <= SEND;
            r_sym_rdy  <= 1'b0;
            r_line_val <= 1'b1;
          end
        end
        SEND: begin
          if (line_rdy) begin
            r_state    <= FILL;
            r_sym_rdy  <= 1'b1;
            r_line_val <= 1'b0;
          end
        end
        default: begin
          r_state    <= FILL;
          r_sym_rdy  <= 1'b1;
          r_line_val <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/rs_encode_line_out_datap.sv
`default_nettype none
// ============================================================================
// Module      : rs_encode_line_out_datap
// Description : Output-side packer of the RS encoder. Packs symbols MSB-first
//               into DATA_W lines; the final line of each NUM_LINES block
//               carries LAST_LINE_BYTES symbols and is zero-padded.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_encode_line_out_datap
  import rs_encode_pkg::*;
#(
  parameter int DATA_W          = 512,
  parameter int DATA_BYTES      = DATA_W / 8,
  parameter int DATA_BYTES_W    = clog2_min1(DATA_BYTES),
  parameter int NUM_LINES       = 4,
  parameter int NUM_LINES_W     = clog2_min1(NUM_LINES),
  parameter int LAST_LINE_BYTES = DATA_BYTES
) (
  input  logic                        clk,
  input  logic                        rst,
  rs_encode_line_out_datap_if.slave   bus
);

  localparam logic [NUM_LINES_W-1:0]  c_final_line = NUM_LINES_W'(NUM_LINES - 1);
  localparam logic [DATA_BYTES_W-1:0] c_full_off   = DATA_BYTES_W'(DATA_BYTES - 1);
  localparam logic [DATA_BYTES_W-1:0] c_short_off  = DATA_BYTES_W'(LAST_LINE_BYTES - 1);

  logic [DATA_BYTES_W-1:0] r_byte_offset;
  logic [NUM_LINES_W-1:0]  r_line_count;
  logic [DATA_W-1:0]       r_line;

  logic w_init_state;
  logic w_store_byte;
  logic w_clear_line;
  logic w_incr_line;
  logic w_last_line;
  logic w_last_line_byte;
  logic w_sym_rdy;
  logic w_line_val;

  rs_encode_line_out_ctrl u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .sym_val        (bus.encoder_out_data_val),
    .line_rdy       (bus.dst_out_line_rdy),
    .last_line_byte (w_last_line_byte),
    .sym_rdy        (w_sym_rdy),
    .line_val       (w_line_val),
    .init_state     (w_init_state),
    .store_byte     (w_store_byte),
    .clear_line     (w_clear_line),
    .incr_line      (w_incr_line)
  );

  // The final line of a block ends early when LAST_LINE_BYTES < DATA_BYTES.
  assign w_last_line      = (r_line_count == c_final_line);
  assign w_last_line_byte = w_last_line ? (r_byte_offset == c_short_off)
                                        : (r_byte_offset == c_full_off);

  // Line value is only presented while valid, so idle outputs read as zero.
  assign bus.out_encoder_data_rdy = w_sym_rdy;
  assign bus.out_dst_line_val     = w_line_val;
  assign bus.out_dst_line         = w_line_val ? r_line : '0;
  assign bus.out_dst_line_last    = w_line_val & w_last_line;

  // Symbol position within the line; cleared explicitly at end of line.
  always_ff @(posedge clk) begin
    if (w_init_state) begin
      r_byte_offset <= '0;
    end else if (w_store_byte) begin
      r_byte_offset <= w_last_line_byte ? '0 : r_byte_offset + 1'b1;
    end
  end

  // Line index within the block; wraps to zero after the final line leaves.
  always_ff @(posedge clk) begin
    if (w_init_state) begin
      r_line_count <= '0;
    end else if (w_incr_line) begin
      r_line_count <= w_last_line ? '0 : r_line_count + 1'b1;
    end
  end

  // Line buffer: MSB-first lane write; clearing on handoff gives the zero pad.
  always_ff @(posedge clk) begin
    if (w_init_state || w_clear_line) begin
      r_line <= '0;
    end else if (w_store_byte) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (r_byte_offset == DATA_BYTES_W'(DATA_BYTES - 1 - i)) begin
          r_line[i*RS_WORD_W +: RS_WORD_W] <= bus.encoder_out_data;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs_encode_line_out_datap.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_encode_line_out_datap
// Description : Self-checking bench for the RS line packer. DUT a uses
//               32-bit lines, 3 lines per block, 2-symbol final line; DUT b
//               uses 32-bit lines, 1 line per block, full final line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_encode_line_out_datap;
  import rs_encode_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rs_encode_line_out_datap_if #(.DATA_W(32)) bus_a ();
  rs_encode_line_out_datap_if #(.DATA_W(32)) bus_b ();

  rs_encode_line_out_datap #(
    .DATA_W(32), .NUM_LINES(3), .LAST_LINE_BYTES(2)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  rs_encode_line_out_datap #(
    .DATA_W(32), .NUM_LINES(1), .LAST_LINE_BYTES(4)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Uniform views of both DUTs for the shared checker.
  logic        s_val  [2];
  logic        s_last [2];
  logic        s_erdy [2];
  logic        s_ev   [2];
  logic        s_drdy [2];
  logic [7:0]  s_ed   [2];
  logic [31:0] s_line [2];
  assign s_val[0]  = bus_a.out_dst_line_val;   assign s_val[1]  = bus_b.out_dst_line_val;
  assign s_last[0] = bus_a.out_dst_line_last;  assign s_last[1] = bus_b.out_dst_line_last;
  assign s_erdy[0] = bus_a.out_encoder_data_rdy; assign s_erdy[1] = bus_b.out_encoder_data_rdy;
  assign s_ev[0]   = bus_a.encoder_out_data_val; assign s_ev[1]   = bus_b.encoder_out_data_val;
  assign s_drdy[0] = bus_a.dst_out_line_rdy;   assign s_drdy[1] = bus_b.dst_out_line_rdy;
  assign s_ed[0]   = bus_a.encoder_out_data;   assign s_ed[1]   = bus_b.encoder_out_data;
  assign s_line[0] = bus_a.out_dst_line;       assign s_line[1] = bus_b.out_dst_line;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lines_per_block(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic int syms_in_line(input int d, input int li);
    if (li == lines_per_block(d) - 1) return (d == 0) ? 2 : 4;
    return 4;
  endfunction

  // Behavioural model: a line becomes pending once enough offered symbols
  // were taken while no line was pending; it leaves when the sink is ready.
  logic        m_pend [2] = '{1'b0, 1'b0};
  int          m_n    [2] = '{0, 0};
  int          m_li   [2] = '{0, 0};
  int          m_dur  [2] = '{0, 0};
  logic [31:0] m_line [2] = '{32'h0, 32'h0};
  logic [32:0] log_a[$];
  logic [32:0] log_b[$];
  int          dur_a[$];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_pend[d] = 1'b0; m_n[d] = 0; m_li[d] = 0; m_dur[d] = 0; m_line[d] = '0;
      end else begin
        chk(d == 0 ? "mon_line_val_a" : "mon_line_val_b", 64'(s_val[d]), 64'(m_pend[d]));
        chk(d == 0 ? "mon_enc_rdy_a" : "mon_enc_rdy_b", 64'(s_erdy[d]), 64'(!m_pend[d]));
        if (m_pend[d]) begin
          chk(d == 0 ? "mon_line_a" : "mon_line_b", 64'(s_line[d]), 64'(m_line[d]));
          chk(d == 0 ? "mon_last_a" : "mon_last_b", 64'(s_last[d]),
              64'(m_li[d] == lines_per_block(d) - 1));
          m_dur[d]++;
          if (s_drdy[d]) begin
            if (d == 0) begin
              log_a.push_back({s_last[d], s_line[d]});
              dur_a.push_back(m_dur[d]);
            end else begin
              log_b.push_back({s_last[d], s_line[d]});
            end
            m_dur[d]  = 0;
            m_pend[d] = 1'b0;
            m_line[d] = '0;
            m_li[d]   = (m_li[d] == lines_per_block(d) - 1) ? 0 : m_li[d] + 1;
          end
        end else if (s_ev[d]) begin
          m_line[d][31 - 8*m_n[d] -: 8] = s_ed[d];
          m_n[d]++;
          if (m_n[d] == syms_in_line(d, m_li[d])) begin
            m_pend[d] = 1'b1;
            m_n[d]    = 0;
          end
        end
      end
    end
  end

  task automatic set_ev(input int d, input logic v, input logic [7:0] s);
    if (d == 0) begin
      bus_a.encoder_out_data_val = v; bus_a.encoder_out_data = s;
    end else begin
      bus_b.encoder_out_data_val = v; bus_b.encoder_out_data = s;
    end
  endtask

  // Offer one symbol (after optional random idle cycles) until accepted.
  task automatic push(input int d, input logic [7:0] s, input int gap_pct);
    int n;
    while (int'($urandom_range(99)) < gap_pct) begin
      set_ev(d, 1'b0, 8'h00);
      @(posedge clk); #1;
    end
    set_ev(d, 1'b1, s);
    n = 0;
    forever begin
      @(negedge clk);
      if (s_erdy[d]) break;
      n++;
      if (n > 200) begin
        chk("push_timeout", 64'(s_erdy[d]), 64'(1));
        break;
      end
    end
    @(posedge clk); #1;
    set_ev(d, 1'b0, 8'h00);
  endtask

  task automatic stream(input int d, input logic [7:0] first, input int count, input int gap_pct);
    for (int i = 0; i < count; i++) push(d, first + 8'(i), gap_pct);
  endtask

  task automatic wait_lines(input int d, input int n);
    int c;
    c = 0;
    while (((d == 0) ? log_a.size() : log_b.size()) < n && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("drain_lines", 64'((d == 0) ? log_a.size() : log_b.size()), 64'(n));
    @(posedge clk); #1;
  endtask

  logic [32:0] exp3 [6];

  initial begin
    exp3[0] = {1'b0, 32'h01020304}; exp3[1] = {1'b0, 32'h05060708};
    exp3[2] = {1'b1, 32'h090A0000}; exp3[3] = {1'b0, 32'h0B0C0D0E};
    exp3[4] = {1'b0, 32'h0F101112}; exp3[5] = {1'b1, 32'h13140000};
    set_ev(0, 1'b0, 8'h00);
    set_ev(1, 1'b0, 8'h00);
    bus_a.dst_out_line_rdy = 1'b1;
    bus_b.dst_out_line_rdy = 1'b1;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_val_a",  64'(bus_a.out_dst_line_val), 64'(0));
    chk("rst_line_a", 64'(bus_a.out_dst_line), 64'(0));
    chk("rst_last_a", 64'(bus_a.out_dst_line_last), 64'(0));
    chk("rst_rdy_a",  64'(bus_a.out_encoder_data_rdy), 64'(1));
    chk("rst_val_b",  64'(bus_b.out_dst_line_val), 64'(0));
    chk("rst_rdy_b",  64'(bus_b.out_encoder_data_rdy), 64'(1));
    @(posedge clk); #1;

    // Back-to-back stream, sink always ready.
    log_a.delete(); dur_a.delete();
    stream(0, 8'h01, 10, 0);
    wait_lines(0, 3);
    for (int i = 0; i < 3 && i < log_a.size(); i++) begin
      chk("s1_line", 64'(log_a[i]), 64'(exp3[i]));
      chk("s1_val_cycles", 64'(dur_a[i]), 64'(1));
    end

    // Sink stalls on line 2.
    log_a.delete(); dur_a.delete();
    fork
      stream(0, 8'h01, 10, 0);
      begin
        int c;
        c = 0;
        do begin @(negedge clk); c++; end
        while (!(bus_a.out_dst_line_val && bus_a.out_dst_line == 32'h01020304) && c < 100);
        chk("s2_line1_seen", 64'(bus_a.out_dst_line), 64'(32'h01020304));
        @(posedge clk); #1 bus_a.dst_out_line_rdy = 1'b0;
        c = 0;
        do begin @(negedge clk); c++; end
        while (!(bus_a.out_dst_line_val && bus_a.out_dst_line == 32'h05060708) && c < 100);
        for (int k = 1; k <= 6; k++) begin
          chk("s2_hold_val", 64'(bus_a.out_dst_line_val), 64'(1));
          chk("s2_hold_line", 64'(bus_a.out_dst_line), 64'(32'h05060708));
          chk("s2_hold_enc_rdy", 64'(bus_a.out_encoder_data_rdy), 64'(0));
          if (k == 5) begin
            @(posedge clk); #1 bus_a.dst_out_line_rdy = 1'b1;
          end
          @(negedge clk);
        end
        chk("s2_after_enc_rdy", 64'(bus_a.out_encoder_data_rdy), 64'(1));
        chk("s2_after_val", 64'(bus_a.out_dst_line_val), 64'(0));
      end
    join
    wait_lines(0, 3);
    if (dur_a.size() >= 2) chk("s2_val_cycles", 64'(dur_a[1]), 64'(6));
    for (int i = 0; i < 3 && i < log_a.size(); i++) chk("s2_line", 64'(log_a[i]), 64'(exp3[i]));

    // Random encoder gaps across two blocks.
    log_a.delete();
    stream(0, 8'h01, 20, 50);
    wait_lines(0, 6);
    for (int i = 0; i < 6 && i < log_a.size(); i++) chk("s3_line", 64'(log_a[i]), 64'(exp3[i]));

    // Reset after two symbols of line 2, then restart.
    stream(0, 8'h01, 6, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("s4_rst_val",  64'(bus_a.out_dst_line_val), 64'(0));
    chk("s4_rst_line", 64'(bus_a.out_dst_line), 64'(0));
    chk("s4_rst_last", 64'(bus_a.out_dst_line_last), 64'(0));
    chk("s4_rst_rdy",  64'(bus_a.out_encoder_data_rdy), 64'(1));
    @(posedge clk); #1;
    log_a.delete();
    stream(0, 8'hA1, 10, 0);
    wait_lines(0, 3);
    if (log_a.size() >= 3) begin
      chk("s4_first_line", 64'(log_a[0]), 64'({1'b0, 32'hA1A2A3A4}));
      chk("s4_final_line", 64'(log_a[2]), 64'({1'b1, 32'hA9AA0000}));
    end

    // Single-line blocks on DUT b.
    log_b.delete();
    push(1, 8'hDE, 0); push(1, 8'hAD, 0); push(1, 8'hBE, 0); push(1, 8'hEF, 0);
    push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 0); push(1, 8'h44, 0);
    wait_lines(1, 2);
    if (log_b.size() >= 2) begin
      chk("s5_line0", 64'(log_b[0]), 64'({1'b1, 32'hDEADBEEF}));
      chk("s5_line1", 64'(log_b[1]), 64'({1'b1, 32'h11223344}));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
